hippo_load_store_unit: RTL and testbench

Data-memory load/store unit for the Hippomenes core, directly downstream of the ALU/register-file stage: it takes the ALU-computed effective address, rs2 data and funct3 for a load or store and runs one request/grant/response transaction on the data-memory port. It stalls the single-cycle core while the transaction is in flight, returns aligned and extended load data for register write-back, and drives the RVFI memory signals that the core top currently ties to zero.

---
 rtl/hippo_decoder_DecoderPkg.sv | 41 ++++
 rtl/hippo_lsu_align.sv | 79 +++++++
 rtl/hippo_load_store_unit.sv | 145 ++++++++++++++
 tb/tb_hippo_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hippo_decoder_DecoderPkg.sv
// Shared load/store decode types: funct3 width codes, LSU FSM states, captured request fields.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package hippo_decoder_DecoderPkg;

  // funct3 width/sign codes shared by loads and stores (stores use B/H/W only)
  typedef enum logic [2:0] {
    LSU_B  = 3'd0,
    LSU_H  = 3'd1,
    LSU_W  = 3'd2,
    LSU_BU = 3'd4,
    LSU_HU = 3'd5
  } LsuWidth;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } LsuState;

  // Request fields frozen at acceptance so memory-side outputs never follow the core inputs
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rvfi_wdata;
    logic [3:0]  rmask;
  } lsu_meta_t;

  // Lane mask of an access starting at lane 0: byte 0001, halfword 0011, word 1111
  function automatic logic [3:0] lsu_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/hippo_lsu_align.sv
// Byte-lane steering: store strobes/data, RVFI masks, misalignment check, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when results are used.
module hippo_lsu_align
  import hippo_decoder_DecoderPkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic        code_ok_o,
  output logic        misaligned_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rvfi_wdata_o,
  output logic [3:0]  rmask_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  // Decode the request side: legality, alignment, store lane placement and read mask
  always_comb begin
    code_ok_o    = 1'b0;
    misaligned_o = 1'b0;
    wstrb_o      = 4'h0;
    wdata_o      = 32'h0;
    rvfi_wdata_o = 32'h0;
    rmask_o      = 4'h0;
    case (funct3_i)
      LSU_B:  code_ok_o = 1'b1;
      LSU_H:  begin code_ok_o = 1'b1; misaligned_o = addr_lo_i[0]; end
      LSU_W:  begin code_ok_o = 1'b1; misaligned_o = |addr_lo_i; end
      LSU_BU: code_ok_o = !is_store_i;
      LSU_HU: begin code_ok_o = !is_store_i; misaligned_o = addr_lo_i[0]; end
      default: ;
    endcase
    if (is_store_i && code_ok_o) begin
      case (funct3_i[1:0])
        2'd0: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        2'd1: begin
          wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_o = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
    // RVFI shows only the bytes actually written
    for (int i = 0; i < 4; i++) begin
      rvfi_wdata_o[8*i +: 8] = wstrb_o[i] ? wdata_o[8*i +: 8] : 8'h00;
    end
    if (!is_store_i && code_ok_o) begin
      rmask_o = lsu_mask(funct3_i) << addr_lo_i;
    end
  end

  // Load path: bring the addressed byte/halfword to bit 0, then sign- or zero-extend
  always_comb begin
    shifted   = ld_raw_i >> {ld_addr_lo_i, 3'b000};
    ld_data_o = shifted;
    case (ld_funct3_i)
      LSU_B:  ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:  ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU: ld_data_o = {24'h0, shifted[7:0]};
      LSU_HU: ld_data_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/hippo_load_store_unit.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction per load or store, with RVFI memory outputs.
// Latency: store 2 cycles, load 3 cycles minimum; grows with grant and read-data delay.
// Backpressure: holds mem_req_o and its payload until mem_gnt_i; stalls the core until done_o.
module hippo_load_store_unit
  import hippo_decoder_DecoderPkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic                 is_store_i,
  input  logic [2:0]           funct3_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic                 misaligned_o,
  output logic [31:0]          rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [3:0]           mem_wstrb_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  output logic [31:0]          rvfi_mem_addr_o,
  output logic [3:0]           rvfi_mem_rmask_o,
  output logic [3:0]           rvfi_mem_wmask_o,
  output logic [31:0]          rvfi_mem_rdata_o,
  output logic [31:0]          rvfi_mem_wdata_o
);

  LsuState              state_q, state_d;
  lsu_meta_t            meta_q, meta_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          raw_q, raw_d;

  logic        code_ok, mis_a;
  logic [3:0]  a_wstrb, a_rmask;
  logic [31:0] a_wdata, a_rvfi_wdata, ld_data;
  logic        stall_raw, mis_raw;
  logic        in_req, in_done;
  logic [AddrWidth-1:0] word_addr;

  hippo_lsu_align u_align (
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_i[1:0]),
    .wdata_i      (wdata_i),
    .code_ok_o    (code_ok),
    .misaligned_o (mis_a),
    .wstrb_o      (a_wstrb),
    .wdata_o      (a_wdata),
    .rvfi_wdata_o (a_rvfi_wdata),
    .rmask_o      (a_rmask),
    .ld_funct3_i  (meta_q.funct3),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_raw_i     (raw_q),
    .ld_data_o    (ld_data)
  );

  // Next state, request capture and core-facing stall/misaligned decode
  always_comb begin
    state_d   = state_q;
    meta_d    = meta_q;
    addr_d    = addr_q;
    raw_d     = raw_q;
    stall_raw = 1'b0;
    mis_raw   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && code_ok) begin
          if (mis_a) begin
            mis_raw = 1'b1;
          end else begin
            stall_raw         = 1'b1;
            state_d           = REQ;
            meta_d.is_store   = is_store_i;
            meta_d.funct3     = funct3_i;
            meta_d.wstrb      = a_wstrb;
            meta_d.wdata      = a_wdata;
            meta_d.rvfi_wdata = a_rvfi_wdata;
            meta_d.rmask      = a_rmask;
            addr_d            = addr_i;
            raw_d             = 32'h0;
          end
        end
      end
      REQ: begin
        stall_raw = 1'b1;
        if (mem_gnt_i) begin
          state_d = meta_q.is_store ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        if (mem_rvalid_i) begin
          raw_d   = mem_rdata_i;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      meta_q  <= '0;
      addr_q  <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      addr_q  <= addr_d;
      raw_q   <= raw_d;
    end
  end

  // Outputs come from captured state only; the core-facing flags are forced low during reset
  always_comb begin
    in_req           = (state_q == REQ);
    in_done          = (state_q == DONE);
    word_addr        = {addr_q[AddrWidth-1:2], 2'b00};
    stall_o          = stall_raw & ~rst_i;
    misaligned_o     = mis_raw & ~rst_i;
    done_o           = in_done;
    rdata_o          = (in_done && !meta_q.is_store) ? ld_data : 32'h0;
    mem_req_o        = in_req;
    mem_we_o         = in_req & meta_q.is_store;
    mem_addr_o       = in_req ? word_addr : '0;
    mem_wstrb_o      = in_req ? meta_q.wstrb : 4'h0;
    mem_wdata_o      = in_req ? meta_q.wdata : 32'h0;
    rvfi_mem_addr_o  = in_done ? 32'(word_addr) : 32'h0;
    rvfi_mem_rmask_o = in_done ? meta_q.rmask : 4'h0;
    rvfi_mem_wmask_o = in_done ? meta_q.wstrb : 4'h0;
    rvfi_mem_rdata_o = in_done ? raw_q : 32'h0;
    rvfi_mem_wdata_o = in_done ? meta_q.rvfi_wdata : 32'h0;
  end

endmodule

// File: tb/tb_hippo_load_store_unit.sv
// Bench for hippo_load_store_unit: directed scenarios plus randomized transactions against a lane model.
// Latency: n/a.
// Backpressure: the bench memory inserts random grant and read-data delays.
module tb_hippo_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i, is_store_i, mem_gnt_i, mem_rvalid_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        stall_o, done_o, misaligned_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o;
  logic [31:0] rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o;
  logic [208:0] all_outs;

  int checks = 0;
  int errors = 0;

  // observations of the last run_txn
  int          o_done_cyc, o_stall_cnt, o_first_req;
  logic        o_unstable, o_leak, o_we;
  logic [31:0] o_addr, o_wdata, o_rdata, o_rv_addr, o_rv_rdata, o_rv_wdata;
  logic [3:0]  o_wstrb, o_rmask, o_wmask;

  always #5 clk_i = ~clk_i;

  assign all_outs = {stall_o, done_o, misaligned_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o,
                     mem_wstrb_o, mem_wdata_o, rvfi_mem_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o,
                     rvfi_mem_rdata_o, rvfi_mem_wdata_o};

  hippo_load_store_unit #(.AddrWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
    .misaligned_o(misaligned_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rvfi_mem_addr_o(rvfi_mem_addr_o), .rvfi_mem_rmask_o(rvfi_mem_rmask_o),
    .rvfi_mem_wmask_o(rvfi_mem_wmask_o), .rvfi_mem_rdata_o(rvfi_mem_rdata_o),
    .rvfi_mem_wdata_o(rvfi_mem_wdata_o)
  );

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_bytes(input int n);
    return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic logic [3:0] m_lanes(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << m_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  // each lane i carries byte (i mod size) of the store data
  function automatic logic [31:0] m_mem_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_size(f3);
    r = 0;
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_rvfi_wdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    return (wd & m_bytes(m_size(f3))) << (8 * (a % 4));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
    logic [31:0] v;
    int n;
    n = m_size(f3);
    v = (raw >> (8 * (a % 4))) & m_bytes(n);
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~m_bytes(n);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    end
  endtask

  // Drives one access with a memory that grants after gd waiting cycles and answers rd cycles later
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] raw, input int gd, input int rd);
    int gnt_cyc, req_cycles;
    gnt_cyc = -1; req_cycles = 0;
    o_done_cyc = -1; o_stall_cnt = 0; o_first_req = -1; o_unstable = 0; o_leak = 0;
    for (int c = 0; c < 40 && o_done_cyc < 0; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        req_valid_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
      end
      mem_gnt_i    = mem_req_o && (req_cycles == gd);
      mem_rvalid_i = !st && gnt_cyc >= 0 && c == gnt_cyc + rd;
      mem_rdata_i  = mem_rvalid_i ? raw : $urandom;
      #1;
      if (stall_o) o_stall_cnt++;
      if (mem_req_o) begin
        if (o_first_req < 0) begin
          o_first_req = c; o_addr = mem_addr_o; o_we = mem_we_o; o_wstrb = mem_wstrb_o; o_wdata = mem_wdata_o;
        end else if ({mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o} !== {o_addr, o_we, o_wstrb, o_wdata}) begin
          o_unstable = 1'b1;
        end
        if (mem_gnt_i) gnt_cyc = c; else req_cycles++;
      end
      if (done_o) begin
        o_done_cyc = c; o_rdata = rdata_o; o_rv_addr = rvfi_mem_addr_o; o_rmask = rvfi_mem_rmask_o;
        o_wmask = rvfi_mem_wmask_o; o_rv_rdata = rvfi_mem_rdata_o; o_rv_wdata = rvfi_mem_wdata_o;
      end else if ({rdata_o, rvfi_mem_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o, rvfi_mem_rdata_o,
                    rvfi_mem_wdata_o} !== '0) begin
        o_leak = 1'b1;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    req_valid_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h100; wdata_i = 32'h1234_5678;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1 rst_i = 1'b1;
    #11;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_outs); end
    @(negedge clk_i);
    req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; rst_i = 1'b0;
    idle(1);
  endtask

  task automatic test_sw;
    run_txn(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0);
    idle(1);
    checks++; if (o_wstrb !== 4'hF) begin errors++; $display("FAIL sw_wstrb got %h want f", o_wstrb); end
    checks++; if (o_addr !== 32'h104) begin errors++; $display("FAIL sw_addr got %h want 104", o_addr); end
    checks++; if (o_done_cyc !== 2) begin errors++; $display("FAIL sw_done_cycle got %0d want 2", o_done_cyc); end
    checks++;
    if ({o_wmask, o_leak} !== {4'hF, 1'b0}) begin
      errors++; $display("FAIL sw_rvfi_wmask got %h leak %b want f leak 0", o_wmask, o_leak);
    end
  endtask

  task automatic test_sb;
    run_txn(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
    idle(1);
    checks++; if (o_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b want 1000", o_wstrb); end
    checks++; if (o_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_wdata); end
    checks++; if (o_rv_wdata !== 32'hA500_0000) begin errors++; $display("FAIL sb_rvfi_wdata got %h want a5000000", o_rv_wdata); end
  endtask

  task automatic test_lb;
    run_txn(1'b0, 3'd0, 32'h102, 32'h0, 32'h1280_3456, 2, 1);
    idle(1);
    checks++; if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", o_rdata); end
    checks++; if (o_stall_cnt !== 5) begin errors++; $display("FAIL lb_stall_cycles got %0d want 5", o_stall_cnt); end
    checks++;
    if ({o_rmask, o_rv_rdata, o_unstable} !== {4'b0100, 32'h1280_3456, 1'b0}) begin
      errors++; $display("FAIL lb_rvfi got rmask %b rdata %h unstable %b want 0100 12803456 0", o_rmask, o_rv_rdata, o_unstable);
    end
    run_txn(1'b0, 3'd4, 32'h102, 32'h0, 32'h1280_3456, 0, 1);
    idle(1);
    checks++; if (o_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h want 00000080", o_rdata); end
  endtask

  task automatic test_misaligned;
    logic req_seen;
    logic [2:0]  f3s [2] = '{3'd1, 3'd2};
    logic [31:0] as  [2] = '{32'h201, 32'h102};
    for (int t = 0; t < 2; t++) begin
      req_seen = 1'b0;
      @(negedge clk_i);
      req_valid_i = 1'b1; is_store_i = (t == 1); funct3_i = f3s[t]; addr_i = as[t]; wdata_i = $urandom;
      #1;
      checks++;
      if ({misaligned_o, stall_o} !== 2'b10) begin
        errors++; $display("FAIL misaligned_flag_%0d got mis %b stall %b want 1 0", t, misaligned_o, stall_o);
      end
      repeat (3) begin @(negedge clk_i); #1; if (mem_req_o || stall_o || done_o) req_seen = 1'b1; end
      checks++;
      if (req_seen !== 1'b0) begin errors++; $display("FAIL misaligned_no_req_%0d got activity %b want 0", t, req_seen); end
      idle(1);
    end
  endtask

  task automatic test_invalid;
    logic act;
    for (int t = 0; t < 2; t++) begin
      act = 1'b0;
      @(negedge clk_i);
      req_valid_i = 1'b1; is_store_i = (t == 1); funct3_i = (t == 1) ? 3'd4 : 3'd3; addr_i = 32'h100;
      #1;
      repeat (3) begin
        if (mem_req_o || stall_o || done_o || misaligned_o) act = 1'b1;
        @(negedge clk_i); #1;
      end
      checks++;
      if (act !== 1'b0) begin errors++; $display("FAIL invalid_code_%0d got activity %b want 0", t, act); end
      idle(1);
    end
  endtask

  task automatic test_reset_wait;
    logic bad;
    // reset while the request is outstanding drops mem_req_o at once
    @(negedge clk_i);
    req_valid_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h400; wdata_i = 32'h1;
    @(negedge clk_i); #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rst_req_setup got %b want 1", mem_req_o); end
    #2 rst_i = 1'b1; #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req_drop got %b want 0", mem_req_o); end
    @(negedge clk_i); rst_i = 1'b0; req_valid_i = 1'b0;
    // load reaches WAIT, then reset, then a stale response
    @(negedge clk_i);
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h300;
    @(negedge clk_i); mem_gnt_i = 1'b1;
    @(negedge clk_i); mem_gnt_i = 1'b0; #1;
    checks++;
    if ({stall_o, mem_req_o} !== 2'b10) begin
      errors++; $display("FAIL rst_wait_setup got stall %b req %b want 1 0", stall_o, mem_req_o);
    end
    #2 rst_i = 1'b1; #1;
    checks++; if (all_outs !== '0) begin errors++; $display("FAIL rst_wait_outputs got %h want 0", all_outs); end
    @(negedge clk_i);
    rst_i = 1'b0; req_valid_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
    bad = 1'b0;
    #1; if (all_outs !== '0) bad = 1'b1;
    @(negedge clk_i); mem_rvalid_i = 1'b0;
    repeat (4) begin #1; if (all_outs !== '0) bad = 1'b1; @(negedge clk_i); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_stale_rvalid got activity %b want 0", bad); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1;
    logic        leak1;
    run_txn(1'b0, 3'd2, 32'h500, 32'h0, 32'h1111_2222, 0, 1);
    r1 = o_rdata; leak1 = o_leak;
    run_txn(1'b0, 3'd5, 32'h506, 32'h0, 32'h9ABC_0000, 1, 2);
    idle(1);
    checks++; if (r1 !== 32'h1111_2222) begin errors++; $display("FAIL b2b_first_rdata got %h want 11112222", r1); end
    checks++; if (o_first_req !== 1) begin errors++; $display("FAIL b2b_second_req_cycle got %0d want 1", o_first_req); end
    checks++; if (o_rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL b2b_second_rdata got %h want 00009abc", o_rdata); end
    checks++; if ({leak1, o_leak} !== 2'b00) begin errors++; $display("FAIL b2b_rvfi_outside_done got %b want 00", {leak1, o_leak}); end
  endtask

  task automatic test_random;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, raw, ev;
    int          gd, rd, k, exp_done;
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, st ? 2 : 4);
      f3 = 3'((k < 3) ? k : k + 1);
      a  = $urandom; a = a & ~32'(m_size(f3) - 1);
      wd = $urandom; raw = $urandom;
      gd = $urandom_range(0, 2); rd = $urandom_range(1, 3);
      exp_done = st ? gd + 2 : gd + 2 + rd;
      run_txn(st, f3, a, wd, raw, gd, rd);
      if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
      else idle(1);
      checks++;
      if ({o_done_cyc, o_stall_cnt, o_first_req} !== {exp_done, exp_done, 1}) begin
        errors++; $display("FAIL rnd%0d_timing got done %0d stall %0d req %0d want %0d %0d 1", n, o_done_cyc, o_stall_cnt, o_first_req, exp_done, exp_done);
      end
      checks++;
      if (o_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_addr got %h want %h", n, o_addr, {a[31:2], 2'b00}); end
      checks++;
      if (st) begin
        if ({o_we, o_wstrb, o_wdata} !== {1'b1, m_lanes(f3, a), m_mem_wdata(f3, wd)}) begin
          errors++; $display("FAIL rnd%0d_store_bus got we %b strb %h data %h want 1 %h %h", n, o_we, o_wstrb, o_wdata, m_lanes(f3, a), m_mem_wdata(f3, wd));
        end
      end else if ({o_we, o_wstrb} !== 5'b0) begin
        errors++; $display("FAIL rnd%0d_load_bus got we %b strb %h want 0 0", n, o_we, o_wstrb);
      end
      checks++;
      if (st) begin
        if ({o_rv_addr, o_rmask, o_wmask, o_rv_wdata} !== {a[31:2], 2'b00, 4'h0, m_lanes(f3, a), m_rvfi_wdata(f3, a, wd)}) begin
          errors++; $display("FAIL rnd%0d_rvfi_store got %h %h %h %h want %h 0 %h %h", n, o_rv_addr, o_rmask, o_wmask, o_rv_wdata, {a[31:2], 2'b00}, m_lanes(f3, a), m_rvfi_wdata(f3, a, wd));
        end
      end else if ({o_rv_addr, o_rmask, o_wmask, o_rv_rdata} !== {a[31:2], 2'b00, m_lanes(f3, a), 4'h0, raw}) begin
        errors++; $display("FAIL rnd%0d_rvfi_load got %h %h %h %h want %h %h 0 %h", n, o_rv_addr, o_rmask, o_wmask, o_rv_rdata, {a[31:2], 2'b00}, m_lanes(f3, a), raw);
      end
      if (!st) begin
        ev = m_load(f3, a, raw);
        checks++;
        if (o_rdata !== ev) begin errors++; $display("FAIL rnd%0d_rdata f3 %0d got %h want %h", n, f3, o_rdata, ev); end
      end
      checks++;
      if ({o_unstable, o_leak} !== 2'b00) begin
        errors++; $display("FAIL rnd%0d_stability got unstable %b leak %b want 0 0", n, o_unstable, o_leak);
      end
    end
  endtask

  initial begin
    req_valid_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    test_reset;
    test_sw;
    test_sb;
    test_lb;
    test_misaligned;
    test_invalid;
    test_reset_wait;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
